// File: rtl/send_queue.sv
// In-order send buffer between the request decoder and the network, with a
// single completion slot that returns a zero write to each request's register.
module send_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request_decoder_send_queue_valid,
  output logic        send_queue_request_decoder_ready,
  input  logic [68:0] request_decoder_send_queue_data,
  output logic        send_queue_network_valid,
  input  logic        network_send_queue_ready,
  output logic [63:0] send_queue_network_data,
  output logic        send_queue_writeback_valid,
  input  logic        writeback_send_queue_ready,
  output logic [36:0] send_queue_writeback_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [68:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        wb_valid;
  logic [4:0]  wb_register;
  logic [68:0] head;
  logic [4:0]  head_register;
  logic        empty, full, push, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign head          = mem[rd_ptr[AW-1:0]];
  assign head_register = head[4:0];

  assign send_queue_request_decoder_ready = !full;
  assign push = request_decoder_send_queue_valid && !full;

  // Only offer a message when its completion has somewhere to go: x0 needs
  // none, otherwise the slot must be free or draining this cycle.
  assign send_queue_network_valid = !empty &&
    (head_register == 5'd0 || !wb_valid || writeback_send_queue_ready);
  assign send_queue_network_data  = head[68:5];
  assign pop = send_queue_network_valid && network_send_queue_ready;

  assign send_queue_writeback_valid = wb_valid;
  assign send_queue_writeback_data  = {wb_register, 32'h0};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= request_decoder_send_queue_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wb_valid    <= 1'b0;
      wb_register <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      // A reload in the same cycle as a drain wins and keeps the slot full.
      if (pop && head_register != 5'd0) begin
        wb_valid    <= 1'b1;
        wb_register <= head_register;
      end else if (writeback_send_queue_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_send_queue.sv
// Directed bench for send_queue: cycle-exact checks plus an in-order scoreboard
// for network messages and completion writes.
module tb_send_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [68:0] req_data;
  logic        net_valid;
  logic        net_ready;
  logic [63:0] net_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [36:0] wb_data;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] net_q [$];
  logic [36:0] wb_q  [$];

  always #5 clk = ~clk;

  send_queue #(.DEPTH(4)) dut (
    .clk                              (clk),
    .rst                              (rst),
    .request_decoder_send_queue_valid (req_valid),
    .send_queue_request_decoder_ready (req_ready),
    .request_decoder_send_queue_data  (req_data),
    .send_queue_network_valid         (net_valid),
    .network_send_queue_ready         (net_ready),
    .send_queue_network_data          (net_data),
    .send_queue_writeback_valid       (wb_valid),
    .writeback_send_queue_ready       (wb_ready),
    .send_queue_writeback_data        (wb_data)
  );

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [68:0] mk(input logic [31:0] meta, input logic [31:0] data,
                                     input logic [4:0] rd);
    return {meta, data, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: handshakes are sampled mid-cycle, expectations enqueued on accept.
  always @(negedge clk) begin
    if (rst) begin
      net_q.delete();
      wb_q.delete();
    end else begin
      if (net_valid && net_ready) begin
        if (net_q.size() == 0) check("net_unexpected", 69'(net_valid), 69'(0));
        else check("net_order", 69'(net_data), 69'(net_q.pop_front()));
      end
      if (wb_valid && wb_ready) begin
        if (wb_q.size() == 0) check("wb_unexpected", 69'(wb_valid), 69'(0));
        else check("wb_order", 69'(wb_data), 69'(wb_q.pop_front()));
      end
      if (req_valid && req_ready) begin
        net_q.push_back(req_data[68:5]);
        if (req_data[4:0] != 5'd0) wb_q.push_back({req_data[4:0], 32'h0});
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_data = '0; net_ready = 1'b0; wb_ready = 1'b0;
    tick();
    tick();
    check("rst_ready", 69'(req_ready), 69'(1));
    check("rst_net_valid", 69'(net_valid), 69'(0));
    check("rst_wb_valid", 69'(wb_valid), 69'(0));
    rst = 1'b0;

    // Single message: network in cycle 1, writeback in cycle 2
    net_ready = 1'b1; wb_ready = 1'b1;
    req_valid = 1'b1; req_data = mk(32'h11, 32'hAA, 5'd5);
    tick();
    req_valid = 1'b0;
    #1;
    check("t1_net_valid", 69'(net_valid), 69'(1));
    check("t1_net_data", 69'(net_data), 69'({32'h11, 32'hAA}));
    check("t1_wb_early", 69'(wb_valid), 69'(0));
    tick();
    check("t1_wb_valid", 69'(wb_valid), 69'(1));
    check("t1_wb_data", 69'(wb_data), 69'({5'd5, 32'h0}));
    tick();
    check("t1_wb_clear", 69'(wb_valid), 69'(0));

    // Fill with network stalled; 5th request must be refused
    net_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_data = mk(32'h20 + i, 32'h200 + i, 5'(i + 1));
      tick();
    end
    check("t2_full_ready", 69'(req_ready), 69'(0));
    req_data = mk(32'h24, 32'h204, 5'd5);
    tick();
    check("t2_still_full", 69'(req_ready), 69'(0));
    req_valid = 1'b0; net_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_valid", 69'(net_valid), 69'(1));
      check("t2_drain_data", 69'(net_data), 69'({32'h20 + i, 32'h200 + i}));
      tick();
    end
    check("t2_empty", 69'(net_valid), 69'(0));
    tick();

    // Writeback back-pressure holds the next message
    wb_ready = 1'b0;
    req_valid = 1'b1; req_data = mk(32'h30, 32'h300, 5'd3);
    tick();
    req_data = mk(32'h70, 32'h700, 5'd7);
    tick();
    req_valid = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("t3_wb_hold_valid", 69'(wb_valid), 69'(1));
      check("t3_wb_hold_data", 69'(wb_data), 69'({5'd3, 32'h0}));
      check("t3_net_blocked", 69'(net_valid), 69'(0));
      tick();
    end
    wb_ready = 1'b1;
    #1;
    check("t3_net_release", 69'(net_valid), 69'(1));
    check("t3_net_data", 69'(net_data), 69'({32'h70, 32'h700}));
    tick();
    check("t3_wb2_valid", 69'(wb_valid), 69'(1));
    check("t3_wb2_data", 69'(wb_data), 69'({5'd7, 32'h0}));
    check("t3_net_idle", 69'(net_valid), 69'(0));
    tick();
    check("t3_wb_clear", 69'(wb_valid), 69'(0));

    // x0 destination passes a full writeback slot and produces no completion
    wb_ready = 1'b0;
    req_valid = 1'b1; req_data = mk(32'h90, 32'h900, 5'd9);
    tick();
    req_data = mk(32'hA0, 32'hA00, 5'd0);
    tick();
    req_valid = 1'b0;
    #1;
    check("t4_x0_valid", 69'(net_valid), 69'(1));
    check("t4_x0_data", 69'(net_data), 69'({32'hA0, 32'hA00}));
    check("t4_slot_full", 69'(wb_data), 69'({5'd9, 32'h0}));
    tick();
    check("t4_net_empty", 69'(net_valid), 69'(0));
    check("t4_wb_held", 69'(wb_valid), 69'(1));
    wb_ready = 1'b1;
    tick();
    check("t4_wb_clear", 69'(wb_valid), 69'(0));
    tick();
    check("t4_no_x0_wb", 69'(wb_valid), 69'(0));

    // Full FIFO: pop and push-valid together refuses the push
    net_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_data = mk(32'h50 + i, 32'h500 + i, 5'(10 + i));
      tick();
    end
    req_data = mk(32'h55, 32'h555, 5'd15); net_ready = 1'b1;
    #1;
    check("t5_refused", 69'(req_ready), 69'(0));
    check("t5_pop_offer", 69'(net_valid), 69'(1));
    tick();
    check("t5_ready_back", 69'(req_ready), 69'(1));
    tick();
    req_valid = 1'b0;
    #1;
    check("t5_occ3_ready", 69'(req_ready), 69'(1));
    for (int i = 0; i < 3; i++) begin
      check("t5_drain_valid", 69'(net_valid), 69'(1));
      tick();
    end
    check("t5_empty", 69'(net_valid), 69'(0));
    tick();
    tick();

    // Reset with entries queued and a completion pending
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_data = mk(32'h60 + i, 32'h600 + i, 5'(21 + i));
      tick();
    end
    req_valid = 1'b0;
    #1;
    check("t6_pre_wb", 69'(wb_valid), 69'(1));
    check("t6_pre_stall", 69'(net_valid), 69'(0));
    rst = 1'b1;
    tick();
    check("t6_rst_ready", 69'(req_ready), 69'(1));
    check("t6_rst_net", 69'(net_valid), 69'(0));
    check("t6_rst_wb", 69'(wb_valid), 69'(0));
    rst = 1'b0; wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_stale_net", 69'(net_valid), 69'(0));
      check("t6_no_stale_wb", 69'(wb_valid), 69'(0));
    end
    req_valid = 1'b1; req_data = mk(32'h77, 32'h777, 5'd17);
    tick();
    req_valid = 1'b0;
    #1;
    check("t6_fresh_data", 69'(net_data), 69'({32'h77, 32'h777}));
    tick();
    tick();
    tick();

    check("sb_net_left", 69'(net_q.size()), 69'(0));
    check("sb_wb_left", 69'(wb_q.size()), 69'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
